// File: rtl/eth_pkg.sv
// CRC-32 constants, FCS generator state type and tkeep helpers.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic {PASS = 1'b0, EXTRA = 1'b1} fcs_state_t;

    // tkeep is contiguous from bit 0, so the population count is the byte count.
    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, keep[i]};
        return cnt;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (4'(i) < n);
        return m;
    endfunction

endpackage

// File: rtl/utils_pkg.sv
// Shared bit-order helpers used to move between wire order and MSB-first CRC order.
package utils_pkg;

    function automatic logic [7:0] bit_reverse8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    function automatic logic [31:0] bit_reverse32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

endpackage

// File: rtl/crc32_d64.sv
// Byte-serial CRC-32 update over the enabled bytes of one 64-bit beat, byte 0 first.
module crc32_d64 (
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [7:0]  keep,
    output logic [31:0] crc_out
);
    import eth_pkg::*;
    import utils_pkg::*;

    logic [31:0] crc_v;
    logic [7:0]  byte_v;
    logic        fb_v;

    always_comb begin
        crc_v  = crc_in;
        byte_v = '0;
        fb_v   = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (keep[b]) begin
                byte_v = bit_reverse8(data[8*b +: 8]);
                for (int i = 7; i >= 0; i--) begin
                    fb_v  = crc_v[31] ^ byte_v[i];
                    crc_v = {crc_v[30:0], 1'b0} ^ (fb_v ? CRC32_POLY : 32'h0);
                end
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/eth_fcs_tx.sv
// Ethernet TX FCS inserter: one register stage, CRC-32 appended after the last valid byte.
module eth_fcs_tx #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
) (
    input  logic              clk156,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
);
    import eth_pkg::*;
    import utils_pkg::*;

    fcs_state_t        state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [KEEP_W-1:0] m_keep_q, m_keep_d;
    logic              m_last_q, m_last_d;
    logic              m_valid_q, m_valid_d;
    logic [31:0]       resid_q, resid_d;
    logic [KEEP_W-1:0] resid_keep_q, resid_keep_d;

    logic [31:0]       crc_next;
    logic [31:0]       fcs;
    logic [DATA_W-1:0] data_masked;
    logic [95:0]       ext;
    logic [3:0]        n;
    logic              out_free;
    logic              accept;

    crc32_d64 u_crc (
        .crc_in  (crc_q),
        .data    (s_axis_tdata),
        .keep    (s_axis_tkeep),
        .crc_out (crc_next)
    );

    assign out_free      = !m_valid_q | m_axis_tready;
    assign s_axis_tready = out_free & (state_q == PASS);
    assign accept        = s_axis_tvalid & s_axis_tready;

    assign n   = keep_count(s_axis_tkeep);
    assign fcs = ~bit_reverse32(crc_next);

    always_comb begin
        data_masked = '0;
        for (int b = 0; b < KEEP_W; b++)
            data_masked[8*b +: 8] = s_axis_tkeep[b] ? s_axis_tdata[8*b +: 8] : 8'h00;
    end

    // Last beat with FCS spliced in at byte n; bits above 63 are the residual for the extra beat.
    assign ext = {32'h0, data_masked} | ({64'h0, fcs} << {n, 3'b000});

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_valid_d    = m_valid_q;
        resid_d      = resid_q;
        resid_keep_d = resid_keep_q;
        case (state_q)
            EXTRA: begin
                // Register holds the full last data beat; swap in the residual once it leaves.
                if (m_valid_q & m_axis_tready) begin
                    m_data_d  = {32'h0, resid_q};
                    m_keep_d  = resid_keep_q;
                    m_last_d  = 1'b1;
                    m_valid_d = 1'b1;
                    state_d   = PASS;
                end
            end
            default: begin
                if (out_free) begin
                    m_valid_d = accept;
                    if (accept) begin
                        if (!s_axis_tlast) begin
                            m_data_d = s_axis_tdata;
                            m_keep_d = s_axis_tkeep;
                            m_last_d = 1'b0;
                            crc_d    = crc_next;
                        end else begin
                            crc_d    = CRC32_INIT;
                            m_data_d = ext[63:0];
                            resid_d  = ext[95:64];
                            if (n <= 4'd4) begin
                                m_keep_d = keep_mask(n + 4'd4);
                                m_last_d = 1'b1;
                            end else begin
                                m_keep_d     = 8'hFF;
                                m_last_d     = 1'b0;
                                resid_keep_d = keep_mask(n - 4'd4);
                                state_d      = EXTRA;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PASS;
            crc_q        <= CRC32_INIT;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            resid_q      <= '0;
            resid_keep_q <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
            resid_q      <= resid_d;
            resid_keep_q <= resid_keep_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tvalid = m_valid_q;

endmodule

// File: tb/tb_eth_fcs_tx.sv
// Bench for eth_fcs_tx: known-answer frame table, corner sequences and a random scoreboard run.
module tb_eth_fcs_tx;

    logic        clk156 = 1'b0;
    logic        rst_n  = 1'b0;
    logic [63:0] s_axis_tdata  = '0;
    logic [7:0]  s_axis_tkeep  = '0;
    logic        s_axis_tlast  = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;

    eth_fcs_tx #(.DATA_W(64), .KEEP_W(8)) dut (
        .clk156        (clk156),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    initial forever #3 clk156 = ~clk156;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        string       msg;
        logic [31:0] fcs;
    } vec_t;

    beat_t       exp_q[$];
    logic [7:0]  out_bytes[$];
    logic [31:0] fcs_hist[$];
    int          total = 0;
    int          bad = 0;
    int          ready_mode = 0;
    bit          mon_en = 1'b1;
    bit          stall_en = 1'b0;
    int          stall_cnt = 0;
    int          beats_cur = 0;
    int          last_frame_beats = 0;
    logic [8:0]  ctl_cur = '0;
    logic [8:0]  ctl_prev = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: reflected CRC-32 (0xEDB88320 is the bit-mirrored 0x04C11DB7), wire byte order.
    function automatic logic [31:0] ref_fcs(input logic [7:0] fr[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            c = c ^ {24'h0, fr[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected output: frame bytes followed by the FCS (LSB first), cut into 8-byte beats.
    task automatic expect_frame(input logic [7:0] fr[$]);
        logic [7:0]  all[$];
        logic [31:0] f;
        beat_t       bt;
        f   = ref_fcs(fr);
        all = fr;
        for (int k = 0; k < 4; k++) all.push_back(f[8*k +: 8]);
        for (int i = 0; i < all.size(); i += 8) begin
            bt.data = '0;
            bt.keep = '0;
            for (int j = 0; j < 8; j++) begin
                if (i + j < all.size()) begin
                    bt.data[8*j +: 8] = all[i+j];
                    bt.keep[j] = 1'b1;
                end
            end
            bt.last = (i + 8 >= all.size());
            exp_q.push_back(bt);
        end
    endtask

    // Present one beat and hold it until accepted; caller is at posedge+1.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t;
        bit ok;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk156);
            ok = s_axis_tready;
            @(posedge clk156);
            #1;
            t++;
        end while (!ok && t < 2000);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no tready expected accept within 2000 cycles");
        end
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int gap_pct);
        int          nb;
        int          left;
        logic [63:0] d;
        logic [7:0]  k;
        expect_frame(fr);
        nb = (fr.size() + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk156);
                #1;
            end
            d    = {$urandom, $urandom};
            k    = '0;
            left = fr.size() - 8*b;
            for (int j = 0; j < 8; j++) begin
                if (j < left) begin
                    d[8*j +: 8] = fr[8*b+j];
                    k[j] = 1'b1;
                end
            end
            send_beat(d, k, b == nb - 1);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(posedge clk156);
            t++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic str_bytes(input string s, output logic [7:0] fr[$]);
        fr.delete();
        for (int i = 0; i < s.len(); i++) fr.push_back(s[i]);
    endtask

    task automatic rand_bytes(input int len, output logic [7:0] fr[$]);
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    endtask

    task automatic check_out_zero(input string name);
        check(name, {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, 32'h0}, 64'h0);
        check({name, "_data"}, m_axis_tdata, 64'h0);
    endtask

    initial forever begin
        @(posedge clk156);
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = $urandom_range(1);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: stability while stalled, scoreboard on handshakes, per-frame capture.
    initial begin
        bit          prev_stall;
        logic [63:0] pd;
        logic [8:0]  pc;
        beat_t       e;
        int          sz;
        prev_stall = 1'b0;
        pd = '0;
        pc = '0;
        forever begin
            @(negedge clk156);
            if (stall_en && !s_axis_tready) stall_cnt++;
            if (prev_stall && rst_n) begin
                check("hold_ctl", {m_axis_tvalid, m_axis_tkeep, m_axis_tlast}, {1'b1, pc});
                check("hold_data", m_axis_tdata, pd);
            end
            prev_stall = rst_n && m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata;
            pc = {m_axis_tkeep, m_axis_tlast};
            if (mon_en && rst_n && m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %h expected no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e.data);
                    check("beat_ctl", {m_axis_tkeep, m_axis_tlast}, {e.keep, e.last});
                end
                for (int j = 0; j < 8; j++)
                    if (m_axis_tkeep[j]) out_bytes.push_back(m_axis_tdata[8*j +: 8]);
                beats_cur++;
                ctl_prev = ctl_cur;
                ctl_cur  = {m_axis_tkeep, m_axis_tlast};
                if (m_axis_tlast) begin
                    sz = out_bytes.size();
                    if (sz >= 4)
                        fcs_hist.push_back({out_bytes[sz-1], out_bytes[sz-2], out_bytes[sz-3], out_bytes[sz-4]});
                    last_frame_beats = beats_cur;
                    beats_cur = 0;
                    out_bytes.delete();
                end
            end
        end
    end

    initial begin
        vec_t        vt[5];
        logic [7:0]  fr[$];
        logic [7:0]  fr2[$];

        vt[0] = '{"123456789", 32'hCBF43926};
        vt[1] = '{"a", 32'hE8B7BE43};
        vt[2] = '{"abc", 32'h352441C2};
        vt[3] = '{"message digest", 32'h20159D7F};
        vt[4] = '{"abcdefghijklmnopqrstuvwxyz", 32'h4C2750BD};

        repeat (3) @(posedge clk156);
        #1;
        check_out_zero("reset_out");
        @(negedge clk156);
        rst_n = 1'b1;
        @(posedge clk156);
        #1;
        check("ready_after_reset", 64'(s_axis_tready), 64'd1);

        // Known-answer frames; lengths cover n=1, n<=4 and n>4 last beats.
        foreach (vt[i]) begin
            str_bytes(vt[i].msg, fr);
            send_frame(fr, 0);
            wait_drain(200);
            check({"kat_fcs_", vt[i].msg}, 64'(fcs_hist[$]), 64'(vt[i].fcs));
            if (i == 0) check("kat_last_ctl", 64'(ctl_cur), {55'h0, 8'h1F, 1'b1});
        end

        rand_bytes(60, fr);
        send_frame(fr, 0);
        wait_drain(200);
        check("f60_beats", 64'(last_frame_beats), 64'd8);
        check("f60_last_ctl", 64'(ctl_cur), {55'h0, 8'hFF, 1'b1});
        check("f60_fcs", 64'(fcs_hist[$]), 64'(ref_fcs(fr)));

        rand_bytes(62, fr);
        stall_cnt = 0;
        stall_en  = 1'b1;
        send_frame(fr, 0);
        wait_drain(200);
        repeat (2) @(posedge clk156);
        #1;
        stall_en = 1'b0;
        check("f62_beats", 64'(last_frame_beats), 64'd9);
        check("f62_prev_ctl", 64'(ctl_prev), {55'h0, 8'hFF, 1'b0});
        check("f62_last_ctl", 64'(ctl_cur), {55'h0, 8'h03, 1'b1});
        check("f62_stall_cycles", 64'(stall_cnt), 64'd1);

        // Back-to-back 9-byte frames, then a 14-byte (EXTRA) frame chased by another.
        str_bytes("123456789", fr);
        stall_cnt = 0;
        stall_en  = 1'b1;
        send_frame(fr, 0);
        send_frame(fr, 0);
        wait_drain(200);
        stall_en = 1'b0;
        check("b2b_stalls", 64'(stall_cnt), 64'd0);
        check("b2b_fcs_first", 64'(fcs_hist[$-1]), 64'hCBF43926);
        check("b2b_fcs_second", 64'(fcs_hist[$]), 64'hCBF43926);
        str_bytes("message digest", fr2);
        send_frame(fr2, 0);
        send_frame(fr, 0);
        wait_drain(200);
        check("extra_then_frame_fcs", 64'(fcs_hist[$]), 64'hCBF43926);

        // Reset in the middle of a frame.
        mon_en = 1'b0;
        send_beat(64'h1122334455667788, 8'hFF, 1'b0);
        send_beat(64'h99AABBCCDDEEFF00, 8'hFF, 1'b0);
        s_axis_tvalid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_out_zero("rst_midframe_out");
        exp_q.delete();
        out_bytes.delete();
        beats_cur = 0;
        repeat (2) @(posedge clk156);
        @(negedge clk156);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk156);
        #1;
        send_frame(fr, 0);
        wait_drain(200);
        check("rst_midframe_fcs", 64'(fcs_hist[$]), 64'hCBF43926);

        // Reset while the residual FCS bytes are pending.
        mon_en     = 1'b0;
        ready_mode = 2;
        @(posedge clk156);
        #1;
        send_beat(64'hDEAD_BEEF_0102_0304, 8'h7F, 1'b1);
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk156);
        @(negedge clk156);
        check("extra_blocks_ready", 64'(s_axis_tready), 64'd0);
        check("extra_held_ctl", 64'({m_axis_tvalid, m_axis_tkeep, m_axis_tlast}), {54'h0, 1'b1, 8'hFF, 1'b0});
        #1;
        rst_n = 1'b0;
        #1;
        check_out_zero("rst_extra_out");
        exp_q.delete();
        out_bytes.delete();
        beats_cur  = 0;
        ready_mode = 0;
        repeat (2) @(posedge clk156);
        @(negedge clk156);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk156);
        #1;
        check("rst_extra_ready", 64'(s_axis_tready), 64'd1);
        send_frame(fr, 0);
        wait_drain(200);
        check("rst_extra_fcs", 64'(fcs_hist[$]), 64'hCBF43926);

        // Random frames with a 50% sink and occasional source idles.
        ready_mode = 1;
        for (int f = 0; f < 150; f++) begin
            rand_bytes($urandom_range(1518, 1), fr);
            send_frame(fr, 10);
        end
        wait_drain(20000);
        ready_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
